seq_det_prog: RTL and testbench

SEQ_DET_PROG -- requirements
Module: seq_det_prog

---
 rtl/seq_det_pkg.sv | 29 ++
 rtl/sat_counter.sv | 43 ++++
 rtl/seq_det_prog.sv | 131 +++++++++++++
 tb/tb_seq_det_prog.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_pkg
// Description : Shared types and defaults for the programmable serial
//               sequence detector (FSM state encoding, reset pattern,
//               configuration length check).
// Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

    // Detector FSM encoding; explicit width keeps the state register 2 bits
    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        RUN   = 2'd1,
        MATCH = 2'd2
    } state_e;

    // Pattern and length the detector comes out of reset with
    localparam logic [4:0] DEF_PATTERN = 5'b01011;
    localparam int         DEF_LEN     = 5;

    // A pattern must be at least two bits and fit in the history register
    function automatic logic len_is_valid(input int unsigned len,
                                          input int unsigned max_len);
        return (len >= 32'd2) && (len <= max_len);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up counter that sticks at all-ones instead of wrapping.
//               clr has priority over inc.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise step unless already saturated
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register, cleared by the active-low asynchronous reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/seq_det_prog.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_prog
// Description : Programmable serial sequence detector. Compares the last
//               len sampled bits against a loadable pattern, raises a
//               registered Moore flag the cycle after the final bit and
//               counts matches with a saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_det_prog
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN     = 16,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(DEF_PATTERN),
    parameter int                 RST_LEN     = DEF_LEN
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         in,
    input  logic                         cfg_load,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         cfg_overlap,
    output logic                         out,
    output logic [CNT_W-1:0]             match_cnt,
    output logic                         cfg_err
);

    localparam int LEN_W = $clog2(MAX_LEN+1);

    state_e             state_q,   state_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [MAX_LEN-1:0] history_q, history_d;
    logic [LEN_W-1:0]   len_q,     len_d;
    logic [LEN_W-1:0]   fill_q,    fill_d;
    logic               overlap_q, overlap_d;
    logic               err_q,     err_d;

    logic [MAX_LEN-1:0] w_shift;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_fill_ok;
    logic               w_hit;
    logic               w_cfg_valid;
    logic [LEN_W-1:0]   w_fill_inc;

    // History as it would look with the current bit shifted in
    assign w_shift = {history_q[MAX_LEN-2:0], in};

    // Only the low len bits of the window take part in the compare
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
        assign w_mask[gi] = (32'(len_q) > gi);
    end

    // Enough fresh bits collected once this one is counted
    assign w_fill_ok   = (({1'b0, fill_q} + (LEN_W+1)'(1)) >= {1'b0, len_q});
    assign w_hit       = en && (state_q != UNCFG) && w_fill_ok &&
                         (((w_shift ^ pattern_q) & w_mask) == '0);
    assign w_cfg_valid = len_is_valid(32'(cfg_len), MAX_LEN);
    assign w_fill_inc  = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);

    // Next-state: configuration load first, then stalled UNCFG, then detection
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        history_d = history_q;
        len_d     = len_q;
        fill_d    = fill_q;
        overlap_d = overlap_q;
        err_d     = err_q;
        if (cfg_load) begin
            if (w_cfg_valid) begin
                pattern_d = cfg_pattern;
                len_d     = cfg_len;
                overlap_d = cfg_overlap;
                history_d = '0;
                fill_d    = '0;
                err_d     = 1'b0;
                state_d   = RUN;
            end else begin
                err_d   = 1'b1;
                state_d = UNCFG;
            end
        end else if (state_q != UNCFG) begin
            state_d = w_hit ? MATCH : RUN;
            if (en) begin
                history_d = w_shift;
                // Without overlap the next match must be built from scratch
                fill_d    = (w_hit && !overlap_q) ? '0 : w_fill_inc;
            end
        end
    end

    // State and configuration registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            pattern_q <= RST_PATTERN;
            len_q     <= LEN_W'(RST_LEN);
            overlap_q <= 1'b1;
            history_q <= '0;
            fill_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            history_q <= history_d;
            fill_q    <= fill_d;
            err_q     <= err_d;
        end
    end

    // A hit coinciding with a load is dropped; a valid load zeroes the count
    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_hit && !cfg_load),
        .clr (cfg_load && w_cfg_valid),
        .cnt (match_cnt)
    );

    assign out     = (state_q == MATCH);
    assign cfg_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_det_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_det_prog
// Description : Directed-vector bench with a scoreboard queue. Two detector
//               instances share stimulus: the default build and one with a
//               2-bit match counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_det_prog;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        in_bit;
    logic        cfg_load;
    logic [15:0] cfg_pattern;
    logic [4:0]  cfg_len;
    logic        cfg_overlap;

    logic        out_a, err_a, out_b, err_b;
    logic [7:0]  cnt_a;
    logic [1:0]  cnt_b;

    int checks   = 0;
    int failures = 0;

    int    exp_o[$];
    int    exp_c[$];
    int    exp_e[$];
    string exp_n[$];
    string tag;

    always #5 clk = ~clk;

    seq_det_prog u_dut (
        .clk(clk), .rst(rst), .en(en), .in(in_bit), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .out(out_a), .match_cnt(cnt_a), .cfg_err(err_a)
    );

    seq_det_prog #(.CNT_W(2)) u_dut_w2 (
        .clk(clk), .rst(rst), .en(en), .in(in_bit), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .out(out_b), .match_cnt(cnt_b), .cfg_err(err_b)
    );

    task automatic chk(input string nm, input string what, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s %s: got %0d expected %0d", nm, what, act, req);
        end
    endtask

    task automatic push(input int eo, input int ec, input int ee);
        exp_o.push_back(eo);
        exp_c.push_back(ec);
        exp_e.push_back(ee);
        exp_n.push_back(tag);
    endtask

    task automatic step(input logic e, input logic b, input int eo, input int ec, input int ee);
        @(negedge clk);
        rst = 1'b1; cfg_load = 1'b0; en = e; in_bit = b;
        push(eo, ec, ee);
    endtask

    task automatic load(input logic [15:0] p, input int l, input logic ov,
                        input int eo, input int ec, input int ee);
        @(negedge clk);
        rst = 1'b1; cfg_load = 1'b1; cfg_pattern = p; cfg_len = 5'(l);
        cfg_overlap = ov; en = 1'b1; in_bit = 1'b1;
        push(eo, ec, ee);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; cfg_load = 1'b0; en = 1'b0; in_bit = 1'b0;
        push(0, 0, 0);
    endtask

    // Monitor: one expected beat per clock, checked just after the edge
    initial begin
        int eo, ec, ee, ec2;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_o.size() > 0) begin
                eo  = exp_o.pop_front();
                ec  = exp_c.pop_front();
                ee  = exp_e.pop_front();
                nm  = exp_n.pop_front();
                ec2 = (ec > 3) ? 3 : ec;
                chk(nm, "out",       int'(out_a), eo);
                chk(nm, "match_cnt", int'(cnt_a), ec);
                chk(nm, "cfg_err",   int'(err_a), ee);
                chk(nm, "out_w2",    int'(out_b), eo);
                chk(nm, "cnt_w2",    int'(cnt_b), ec2);
                chk(nm, "err_w2",    int'(err_b), ee);
            end
        end
    end

    initial begin
        rst = 1'b0; en = 1'b0; in_bit = 1'b0; cfg_load = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;

        tag = "reset_default";
        do_reset();
        step(1, 0, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0); step(1, 1, 1, 1, 0); step(0, 0, 0, 1, 0);

        tag = "p101_overlap";
        load(16'b101, 3, 1'b1, 0, 0, 0);
        step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 0); step(1, 1, 1, 1, 0);
        step(1, 0, 0, 1, 0); step(1, 1, 1, 2, 0); step(0, 0, 0, 2, 0);

        tag = "p101_no_overlap";
        load(16'b101, 3, 1'b0, 0, 0, 0);
        step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 0); step(1, 1, 1, 1, 0);
        step(1, 0, 0, 1, 0); step(1, 1, 0, 1, 0);

        tag = "p11_run";
        load(16'b11, 2, 1'b1, 0, 0, 0);
        step(1, 1, 0, 0, 0); step(1, 1, 1, 1, 0); step(1, 1, 1, 2, 0);
        step(1, 1, 1, 3, 0); step(0, 1, 0, 3, 0);

        tag = "en_gap";
        load(16'b01011, 5, 1'b1, 0, 0, 0);
        step(1, 0, 0, 0, 0); step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 1, 1, 1, 0);
        step(0, 0, 0, 1, 0);

        tag = "cfg_err";
        load(16'b01011, 1, 1'b1, 0, 1, 1);
        step(1, 0, 0, 1, 1); step(1, 1, 0, 1, 1); step(1, 0, 0, 1, 1);
        step(1, 1, 0, 1, 1); step(1, 1, 0, 1, 1);
        load(16'b01011, 17, 1'b1, 0, 1, 1);
        load(16'b01011, 5, 1'b1, 0, 0, 0);
        step(1, 0, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0); step(1, 1, 1, 1, 0);

        tag = "saturate";
        load(16'b11, 2, 1'b1, 0, 0, 0);
        step(1, 1, 0, 0, 0); step(1, 1, 1, 1, 0); step(1, 1, 1, 2, 0);
        step(1, 1, 1, 3, 0); step(1, 1, 1, 4, 0); step(1, 1, 1, 5, 0);
        tag = "load_beats_hit";
        load(16'b11, 2, 1'b1, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        tag = "reset_midstream";
        do_reset();
        step(1, 0, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0); step(1, 1, 1, 1, 0);
        step(1, 0, 0, 1, 0); step(1, 1, 0, 1, 0); step(1, 0, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        do_reset();
        step(1, 1, 0, 0, 0); step(0, 0, 0, 0, 0);

        tag = "drain";
        for (int i = 0; i < 10 && exp_o.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_o.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending beats expected 0", exp_o.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
